// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the 8259 interrupt-acknowledge sequencer.
package pic_pkg;
    typedef enum logic [2:0] {IDLE, P1_LOW, GAP, P2_LOW, VEC_HOLD, EOI_WR, EOI_REC} state_t;
    localparam logic [7:0] EOI_NONSPEC = 8'h20;
    localparam logic       OCW2_A0     = 1'b0;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};
endmodule

// File: rtl/inta_sequencer.sv
// inta_sequencer: drives the 8259 two-pulse INTA handshake, captures the vector and issues EOI writes.
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int         INTA_LOW_CYC = 2,
    parameter int         INTA_GAP_CYC = 2,
    parameter int         WR_LOW_CYC   = 2,
    parameter logic [7:0] EOI_DATA     = EOI_NONSPEC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INT,
    input  logic       int_enable,
    output logic       INTA,
    input  logic [7:0] data_in,
    output logic       WR,
    output logic       A0,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [7:0] vec,
    output logic       vec_valid,
    input  logic       vec_ready,
    output logic       spurious,
    input  logic       eoi_req,
    output logic       busy
);
    localparam int MAX_A   = INTA_LOW_CYC > INTA_GAP_CYC ? INTA_LOW_CYC : INTA_GAP_CYC;
    localparam int MAX_CYC = MAX_A > WR_LOW_CYC ? MAX_A : WR_LOW_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    state_t          state, nxt;
    logic [CW-1:0]   cnt, cnt_n, lim;
    logic            int_sync, eoi_pend, pend_n, last, capture, drive, vv_n;

    sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(INT), .q(int_sync));

    always_comb begin
        lim = state inside {P1_LOW, P2_LOW} ? CW'(INTA_LOW_CYC - 1) :
              state == GAP                  ? CW'(INTA_GAP_CYC - 1) : CW'(WR_LOW_CYC - 1);
        last = cnt == lim;
        nxt = state;
        case (state)
            IDLE:     nxt = (eoi_pend || eoi_req)              ? EOI_WR :
                            (int_sync && int_enable && !vec_valid) ? P1_LOW : IDLE;
            P1_LOW:   nxt = last ? GAP : P1_LOW;
            GAP:      nxt = last ? P2_LOW : GAP;
            P2_LOW:   nxt = last ? VEC_HOLD : P2_LOW;
            VEC_HOLD: nxt = (vec_valid && vec_ready) ? IDLE : VEC_HOLD;
            EOI_WR:   nxt = last ? EOI_REC : EOI_WR;
            EOI_REC:  nxt = IDLE;
            default:  nxt = IDLE;
        endcase
        cnt_n   = (nxt != state || state inside {IDLE, VEC_HOLD}) ? '0 : cnt + 1'b1;
        // A request that lands in a busy state is parked until the FSM returns to IDLE.
        pend_n  = (nxt == EOI_WR && state != EOI_WR) ? 1'b0 : eoi_pend | (eoi_req && state != IDLE);
        capture = state == P2_LOW && last;
        vv_n    = capture ? 1'b1 : (state == VEC_HOLD && vec_ready) ? 1'b0 : vec_valid;
        drive   = nxt inside {EOI_WR, EOI_REC};
    end

    // Outputs are registered from the next state so INTA/WR change cleanly on the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            eoi_pend  <= 1'b0;
            INTA      <= 1'b1;
            WR        <= 1'b1;
            A0        <= 1'b1;
            data_out  <= 8'h00;
            data_oe   <= 1'b0;
            vec       <= 8'h00;
            vec_valid <= 1'b0;
            spurious  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= cnt_n;
            eoi_pend  <= pend_n;
            INTA      <= !(nxt inside {P1_LOW, P2_LOW});
            WR        <= nxt != EOI_WR;
            A0        <= drive ? OCW2_A0 : 1'b1;
            data_out  <= drive ? EOI_DATA : 8'h00;
            data_oe   <= drive;
            if (capture) vec <= data_in;
            vec_valid <= vv_n;
            spurious  <= capture && !int_sync;
            busy      <= nxt != IDLE;
        end
    end
endmodule
